chirp_sweeper: RTL and testbench

CHIRP_SWEEPER -- requirements
Module: chirp_sweeper

---
 rtl/chirp_sweeper.sv | 181 ++++++++++++++++++
 tb/tb_chirp_sweeper.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/chirp_sweeper.sv
// Chirp sweeper: steps a registered tuning word from f_start toward f_stop
// in f_inc increments, holding each word for a programmable dwell period.
// Mode 0 performs one up-sweep and pulses done; mode 1 sweeps a continuous
// triangle between f_start and f_stop until aborted or reset.
module chirp_sweeper (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        mode,
    input  logic [31:0] f_start,
    input  logic [31:0] f_stop,
    input  logic [31:0] f_inc,
    input  logic [15:0] dwell,
    output logic [31:0] phase_step,
    output logic        busy,
    output logic        done
);

    localparam int unsigned WORD_W  = 32;
    localparam int unsigned DWELL_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        DOWN = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [WORD_W-1:0]   phase_d;
    logic                busy_d;
    logic                done_d;
    logic [DWELL_W-1:0]  cnt_q;
    logic [DWELL_W-1:0]  cnt_d;

    // Configuration captured at the accepted start edge
    logic [WORD_W-1:0]   start_q;
    logic [WORD_W-1:0]   stop_q;
    logic [WORD_W-1:0]   inc_q;
    logic [DWELL_W-1:0]  dwell_q;
    logic                mode_q;
    logic                cfg_load;

    // Dwell reload values: a dwell of 0 behaves as 1, so reload is max(dwell,1)-1
    logic [DWELL_W-1:0]  reload_new;
    logic [DWELL_W-1:0]  reload_cur;

    // 33-bit arithmetic so carry out / borrow are visible
    logic [WORD_W:0]     sum;
    logic [WORD_W:0]     diff;
    logic                borrow;

    // Reload values and next-word arithmetic
    always_comb begin
        reload_new = (dwell == '0)   ? '0 : dwell   - DWELL_W'(1);
        reload_cur = (dwell_q == '0) ? '0 : dwell_q - DWELL_W'(1);
        sum        = {1'b0, phase_step} + {1'b0, inc_q};
        diff       = {1'b0, phase_step} - {1'b0, inc_q};
        borrow     = diff[WORD_W];
    end

    // State, output and dwell-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            phase_step <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            phase_step <= phase_d;
            busy       <= busy_d;
            done       <= done_d;
            cnt_q      <= cnt_d;
        end
    end

    // Configuration latch, written only on an accepted start
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            start_q <= '0;
            stop_q  <= '0;
            inc_q   <= '0;
            dwell_q <= '0;
            mode_q  <= 1'b0;
        end else if (cfg_load) begin
            start_q <= f_start;
            stop_q  <= f_stop;
            inc_q   <= f_inc;
            dwell_q <= dwell;
            mode_q  <= mode;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_step;
        busy_d   = busy;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        cfg_load = 1'b0;

        case (state_q)
            IDLE: begin
                // Abort wins over a simultaneous start
                if (start && !abort) begin
                    cfg_load = 1'b1;
                    phase_d  = f_start;
                    if (f_inc == '0 || f_stop <= f_start) begin
                        // Nothing to sweep: report completion immediately
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end else begin
                        state_d = UP;
                        busy_d  = 1'b1;
                        cnt_d   = reload_new;
                    end
                end
            end

            UP: begin
                if (abort) begin
                    state_d = IDLE;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d = reload_cur;
                    if (sum >= {1'b0, stop_q}) begin
                        // Clamp at the upper word; never wrap
                        phase_d = stop_q;
                        if (mode_q) begin
                            state_d = DOWN;
                        end else begin
                            state_d = IDLE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            cnt_d   = '0;
                        end
                    end else begin
                        phase_d = sum[WORD_W-1:0];
                    end
                end
            end

            DOWN: begin
                if (abort) begin
                    state_d = IDLE;
                    phase_d = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - DWELL_W'(1);
                end else begin
                    cnt_d = reload_cur;
                    if (borrow || diff[WORD_W-1:0] <= start_q) begin
                        // Clamp at the lower word and turn around
                        phase_d = start_q;
                        state_d = UP;
                    end else begin
                        phase_d = diff[WORD_W-1:0];
                    end
                end
            end

            default: begin
                state_d = IDLE;
                phase_d = '0;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_chirp_sweeper.sv
// Directed testbench for chirp_sweeper: single sweep, clamp, degenerate,
// overflow, triangle, async reset and abort scenarios.
module tb_chirp_sweeper;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic        mode;
    logic [31:0] f_start;
    logic [31:0] f_stop;
    logic [31:0] f_inc;
    logic [15:0] dwell;
    logic [31:0] phase_step;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    chirp_sweeper dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .mode       (mode),
        .f_start    (f_start),
        .f_stop     (f_stop),
        .f_inc      (f_inc),
        .dwell      (dwell),
        .phase_step (phase_step),
        .busy       (busy),
        .done       (done)
    );

    // 10-unit clock period
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [31:0] ps, input logic b, input logic d);
        chk({tag, " phase_step"}, phase_step, ps);
        chk({tag, " busy"}, 32'(busy), 32'(b));
        chk({tag, " done"}, 32'(done), 32'(d));
    endtask

    // Present a configuration with start for one edge; returns just after edge E
    task automatic go(input logic [31:0] fs, input logic [31:0] fe,
                      input logic [31:0] fi, input logic [15:0] dw, input logic md);
        f_start = fs;
        f_stop  = fe;
        f_inc   = fi;
        dwell   = dw;
        mode    = md;
        start   = 1'b1;
        tick();
        start   = 1'b0;
    endtask

    logic [31:0] tri_exp [7];

    initial begin
        tri_exp = '{32'd0, 32'd10, 32'd20, 32'd10, 32'd0, 32'd10, 32'd20};
        reset   = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        mode    = 1'b0;
        f_start = '0;
        f_stop  = '0;
        f_inc   = '0;
        dwell   = '0;

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk_out("reset", 32'd0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        chk_out("idle", 32'd0, 1'b0, 1'b0);

        // Single sweep 100..130 step 10 dwell 2; inputs changed after start are ignored
        go(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
        chk_out("single E", 32'd100, 1'b1, 1'b0);
        f_stop = 32'd1000;
        f_inc  = 32'd1;
        dwell  = 16'd7;
        tick(); chk_out("single E+1", 32'd100, 1'b1, 1'b0);
        tick(); chk_out("single E+2", 32'd110, 1'b1, 1'b0);
        tick(); chk_out("single E+3", 32'd110, 1'b1, 1'b0);
        tick(); chk_out("single E+4", 32'd120, 1'b1, 1'b0);
        tick(); chk_out("single E+5", 32'd120, 1'b1, 1'b0);
        tick(); chk_out("single E+6", 32'd130, 1'b0, 1'b1);
        tick(); chk_out("single E+7", 32'd130, 1'b0, 1'b0);

        // Degenerate: f_stop <= f_start
        go(32'd40, 32'd40, 32'd5, 16'd1, 1'b0);
        chk_out("degen stop", 32'd40, 1'b0, 1'b1);
        tick(); chk_out("degen stop+1", 32'd40, 1'b0, 1'b0);

        // Degenerate: f_inc == 0
        go(32'd7, 32'd90, 32'd0, 16'd3, 1'b1);
        chk_out("degen inc", 32'd7, 1'b0, 1'b1);
        tick(); chk_out("degen inc+1", 32'd7, 1'b0, 1'b0);

        // Clamp with dwell 0 (treated as 1)
        go(32'd0, 32'd25, 32'd10, 16'd0, 1'b0);
        chk_out("clamp E", 32'd0, 1'b1, 1'b0);
        tick(); chk_out("clamp E+1", 32'd10, 1'b1, 1'b0);
        tick(); chk_out("clamp E+2", 32'd20, 1'b1, 1'b0);
        tick(); chk_out("clamp E+3", 32'd25, 1'b0, 1'b1);

        // Overflow near the top of the word range: clamp, no wrap
        go(32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'h10, 16'd1, 1'b0);
        chk_out("ovf E", 32'hFFFF_FFF0, 1'b1, 1'b0);
        tick(); chk_out("ovf E+1", 32'hFFFF_FFFF, 1'b0, 1'b1);
        tick(); chk_out("ovf E+2", 32'hFFFF_FFFF, 1'b0, 1'b0);

        // Triangle; a start while busy (with a different f_start) must be ignored
        go(32'd0, 32'd20, 32'd10, 16'd1, 1'b1);
        chk_out("tri 0", tri_exp[0], 1'b1, 1'b0);
        for (int i = 1; i < 7; i++) begin
            if (i == 3) begin
                f_start = 32'd500;
                start   = 1'b1;
            end
            tick();
            start = 1'b0;
            chk_out($sformatf("tri %0d", i), tri_exp[i], 1'b1, 1'b0);
        end

        // Async reset mid-triangle: outputs clear before any clock edge
        #2 reset = 1'b1;
        #1;
        chk_out("async reset", 32'd0, 1'b0, 1'b0);
        f_start = 32'd50;
        f_stop  = 32'd70;
        f_inc   = 32'd10;
        dwell   = 16'd1;
        mode    = 1'b0;
        start   = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick();
        start = 1'b0;
        chk_out("post-reset E", 32'd50, 1'b1, 1'b0);
        tick(); chk_out("post-reset E+1", 32'd60, 1'b1, 1'b0);
        tick(); chk_out("post-reset E+2", 32'd70, 1'b0, 1'b1);

        // Abort mid-sweep
        go(32'd100, 32'd130, 32'd10, 16'd2, 1'b0);
        chk_out("abort E", 32'd100, 1'b1, 1'b0);
        tick();
        tick(); chk_out("abort E+2", 32'd110, 1'b1, 1'b0);
        abort = 1'b1;
        tick(); chk_out("abort taken", 32'd0, 1'b0, 1'b0);

        // Start together with abort in IDLE is ignored
        start = 1'b1;
        tick(); chk_out("start+abort", 32'd0, 1'b0, 1'b0);
        start = 1'b0;
        abort = 1'b0;
        tick(); chk_out("after start+abort", 32'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
